// File: rtl/gfx_axib_chop.sv
// gfx_axib_chop: AXI4 burst splitter that re-issues bursts as sub-bursts capped at MAX_LEN beats and never crossing BOUNDARY.
// Define GFX_AXIB_CHOP_STATS_EN to add the rd_splits/wr_splits sub-burst counters.
module gfx_axib_chop #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_LEN  = 16,
    parameter int BOUNDARY = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [7:0]        s_awlen,
    input  logic [1:0]        s_awburst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic              s_wlast,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [7:0]        s_arlen,
    input  logic [1:0]        s_arburst,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              s_rlast,
    output logic [DATA_W-1:0] s_rdata,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [7:0]        m_awlen,
    output logic [1:0]        m_awburst,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic              m_wlast,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [7:0]        m_arlen,
    output logic [1:0]        m_arburst,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic              m_rlast,
    input  logic [DATA_W-1:0] m_rdata
`ifdef GFX_AXIB_CHOP_STATS_EN
    ,
    output logic [31:0]       rd_splits,
    output logic [31:0]       wr_splits
`endif
);
    localparam int BB  = DATA_W / 8;
    localparam int BSH = $clog2(BB);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(BB - 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRESP} w_state_t;

    // FIXED bursts never advance, so only the MAX_LEN cap applies to them
    function automatic logic [8:0] sub_beats(input logic [ADDR_W-1:0] a, input logic [8:0] rem, input logic fixed);
        logic [ADDR_W:0] room;
        logic [8:0]      n;
        room = ((ADDR_W+1)'(BOUNDARY) - (ADDR_W+1)'(a & ADDR_W'(BOUNDARY - 1))) >> BSH;
        n = (rem < 9'(MAX_LEN)) ? rem : 9'(MAX_LEN);
        return (!fixed && room < (ADDR_W+1)'(n)) ? room[8:0] : n;
    endfunction

    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [8:0]        r_rem_q, r_rem_d, r_n;
    logic              r_fixed_q, r_fixed_d;
    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [8:0]        w_rem_q, w_rem_d, w_n;
    logic [8:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic              w_fixed_q, w_fixed_d;
    logic              unused_wlast;

    assign unused_wlast = s_wlast;
    assign r_n = sub_beats(r_addr_q, r_rem_q, r_fixed_q);
    assign w_n = sub_beats(w_addr_q, w_rem_q, w_fixed_q);

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_rem_d   = r_rem_q;
        r_fixed_d = r_fixed_q;
        s_arready = r_state_q == R_IDLE;
        m_arvalid = r_state_q == R_ADDR;
        m_araddr  = r_addr_q;
        m_arlen   = 8'(r_n - 9'd1);
        m_arburst = r_fixed_q ? 2'b00 : 2'b01;
        s_rvalid  = r_state_q == R_DATA && m_rvalid;
        m_rready  = r_state_q == R_DATA && s_rready;
        s_rdata   = m_rdata;
        s_rlast   = r_state_q == R_DATA && m_rlast && r_rem_q == 9'd0;
        if (s_arvalid && s_arready) begin
            r_addr_d  = s_araddr & ALIGN;
            r_rem_d   = {1'b0, s_arlen} + 9'd1;
            r_fixed_d = s_arburst == 2'b00;
            r_state_d = R_ADDR;
        end else if (m_arvalid && m_arready) begin
            r_rem_d   = r_rem_q - r_n;
            r_addr_d  = r_fixed_q ? r_addr_q : r_addr_q + (ADDR_W'(r_n) << BSH);
            r_state_d = R_DATA;
        end else if (s_rvalid && s_rready && m_rlast) begin
            r_state_d = r_rem_q == 9'd0 ? R_IDLE : R_ADDR;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_rem_d   = w_rem_q;
        w_fixed_d = w_fixed_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        s_awready = w_state_q == W_IDLE;
        m_awvalid = w_state_q == W_ADDR;
        m_awaddr  = w_addr_q;
        m_awlen   = 8'(w_n - 9'd1);
        m_awburst = w_fixed_q ? 2'b00 : 2'b01;
        m_wvalid  = w_state_q == W_DATA && s_wvalid;
        s_wready  = w_state_q == W_DATA && m_wready;
        m_wdata   = s_wdata;
        m_wlast   = w_state_q == W_DATA && w_cnt_q == w_len_q;
        m_bready  = w_state_q == W_RESP;
        s_bvalid  = w_state_q == W_BRESP;
        if (s_awvalid && s_awready) begin
            w_addr_d  = s_awaddr & ALIGN;
            w_rem_d   = {1'b0, s_awlen} + 9'd1;
            w_fixed_d = s_awburst == 2'b00;
            w_state_d = W_ADDR;
        end else if (m_awvalid && m_awready) begin
            w_rem_d   = w_rem_q - w_n;
            w_addr_d  = w_fixed_q ? w_addr_q : w_addr_q + (ADDR_W'(w_n) << BSH);
            w_len_d   = w_n - 9'd1;
            w_cnt_d   = 9'd0;
            w_state_d = W_DATA;
        end else if (m_wvalid && m_wready) begin
            w_cnt_d   = w_cnt_q + 9'd1;
            w_state_d = m_wlast ? W_RESP : W_DATA;
        end else if (m_bready && m_bvalid) begin
            w_state_d = w_rem_q == 9'd0 ? W_BRESP : W_ADDR;
        end else if (s_bvalid && s_bready) begin
            w_state_d = W_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_rem_q   <= '0;
            r_fixed_q <= 1'b0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_rem_q   <= '0;
            w_fixed_q <= 1'b0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_rem_q   <= r_rem_d;
            r_fixed_q <= r_fixed_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_rem_q   <= w_rem_d;
            w_fixed_q <= w_fixed_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
        end
    end

`ifdef GFX_AXIB_CHOP_STATS_EN
    // Sub-bursts issued so far for the current burst, folded into the total on the final one
    logic [8:0]  rd_sub_q, rd_sub_d, wr_sub_q, wr_sub_d;
    logic [31:0] rd_splits_q, rd_splits_d, wr_splits_q, wr_splits_d;

    assign rd_splits = rd_splits_q;
    assign wr_splits = wr_splits_q;

    always_comb begin
        rd_sub_d    = (s_arvalid && s_arready) ? 9'd0 : rd_sub_q;
        wr_sub_d    = (s_awvalid && s_awready) ? 9'd0 : wr_sub_q;
        rd_splits_d = rd_splits_q;
        wr_splits_d = wr_splits_q;
        if (m_arvalid && m_arready) begin
            rd_sub_d    = rd_sub_q + 9'd1;
            rd_splits_d = r_rem_q == r_n ? rd_splits_q + 32'(rd_sub_q) : rd_splits_q;
        end
        if (m_awvalid && m_awready) begin
            wr_sub_d    = wr_sub_q + 9'd1;
            wr_splits_d = w_rem_q == w_n ? wr_splits_q + 32'(wr_sub_q) : wr_splits_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sub_q    <= '0;
            wr_sub_q    <= '0;
            rd_splits_q <= '0;
            wr_splits_q <= '0;
        end else begin
            rd_sub_q    <= rd_sub_d;
            wr_sub_q    <= wr_sub_d;
            rd_splits_q <= rd_splits_d;
            wr_splits_q <= wr_splits_d;
        end
    end
`endif
endmodule

// File: tb/tb_gfx_axib_chop.sv
// tb_gfx_axib_chop: directed and randomized bench for gfx_axib_chop against a burst-splitting reference model.
module tb_gfx_axib_chop;
    localparam int BB = 4, MAX_LEN = 16, BOUNDARY = 4096;

    logic clk = 1'b0, rst = 1'b1;
    logic s_awvalid = 0, s_awready, s_wvalid = 0, s_wready, s_wlast = 0, s_bvalid, s_bready = 0;
    logic [7:0] s_awlen = 0, s_arlen = 0, m_awlen, m_arlen;
    logic [1:0] s_awburst = 0, s_arburst = 0, m_awburst, m_arburst;
    logic [31:0] s_awaddr = 0, s_araddr = 0, m_awaddr, m_araddr;
    logic [31:0] s_wdata = 0, s_rdata, m_wdata, m_rdata = 0;
    logic s_arvalid = 0, s_arready, s_rvalid, s_rready = 0, s_rlast;
    logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_wlast, m_bvalid = 0, m_bready;
    logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, m_rlast = 0;
`ifdef GFX_AXIB_CHOP_STATS_EN
    logic [31:0] rd_splits, wr_splits;
`endif

    int checks = 0, errors = 0;
    longint exp_rd_splits = 0, exp_wr_splits = 0;
    longint unsigned eq_addr[$];
    int eq_len[$];

    gfx_axib_chop dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arlen(s_arlen), .s_arburst(s_arburst), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arlen(m_arlen), .m_arburst(m_arburst), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata)
`ifdef GFX_AXIB_CHOP_STATS_EN
        , .rd_splits(rd_splits), .wr_splits(wr_splits)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: carve the burst into pieces limited by remaining beats, MAX_LEN and distance to the next boundary
    function automatic void split(input logic [31:0] a, input int len, input logic [1:0] bt);
        longint unsigned addr = a & ~32'(BB - 1);
        int rem = len + 1, n, room;
        eq_addr.delete();
        eq_len.delete();
        while (rem > 0) begin
            n = rem < MAX_LEN ? rem : MAX_LEN;
            room = int'((BOUNDARY - (addr % BOUNDARY)) / BB);
            if (bt != 2'b00 && room < n) n = room;
            eq_addr.push_back(addr);
            eq_len.push_back(n - 1);
            rem -= n;
            if (bt != 2'b00) addr = (addr + longint'(n * BB)) & 64'hFFFF_FFFF;
        end
    endfunction

    task automatic rd(input logic [31:0] a, input int len, input logic [1:0] bt, input bit bp, input int ard);
        int beat = 0, total = len + 1, t;
        bit tog = 1'b1, done;
        logic [31:0] d;
        split(a, len, bt);
        exp_rd_splits += eq_addr.size() - 1;
        @(negedge clk);
        s_arvalid = 1; s_araddr = a; s_arlen = 8'(len); s_arburst = bt;
        #1 chk("s_arready_idle", s_arready, 1);
        @(negedge clk);
        s_arvalid = 0;
        for (int k = 0; k < eq_addr.size(); k++) begin
            #1 t = 0;
            while (!m_arvalid && t < 20) begin @(negedge clk); #1 t++; end
            chk("m_arvalid", m_arvalid, 1);
            chk("m_araddr", m_araddr, eq_addr[k]);
            chk("m_arlen", m_arlen, eq_len[k]);
            chk("m_arburst", m_arburst, bt == 2'b00 ? 2'b00 : 2'b01);
            chk("s_arready_busy", s_arready, 0);
            for (int i = 0; i < ard; i++) begin
                @(negedge clk); #1;
                chk("ar_hold_valid", m_arvalid, 1);
                chk("ar_hold_addr", m_araddr, eq_addr[k]);
                chk("ar_hold_len", m_arlen, eq_len[k]);
            end
            m_arready = 1;
            @(negedge clk);
            m_arready = 0;
            for (int i = 0; i <= eq_len[k]; i++) begin
                d = $urandom;
                done = 0;
                while (!done) begin
                    m_rvalid = 1; m_rdata = d; m_rlast = i == eq_len[k];
                    s_rready = bp ? tog : 1'b1;
                    tog = ~tog;
                    #1;
                    chk("s_rvalid", s_rvalid, 1);
                    chk("s_rdata", s_rdata, d);
                    chk("s_rlast", s_rlast, beat == total - 1);
                    chk("m_rready", m_rready, s_rready);
                    done = s_rready;
                    @(negedge clk);
                end
                beat++;
            end
            m_rvalid = 0; m_rlast = 0; s_rready = 0;
        end
        #1 chk("rd_beats", beat, total);
        chk("s_arready_done", s_arready, 1);
        chk("s_rvalid_done", s_rvalid, 0);
    endtask

    task automatic wr(input logic [31:0] a, input int len, input logic [1:0] bt, input bit bp, input int brd);
        int t;
        bit done;
        logic [31:0] d;
        split(a, len, bt);
        exp_wr_splits += eq_addr.size() - 1;
        @(negedge clk);
        s_awvalid = 1; s_awaddr = a; s_awlen = 8'(len); s_awburst = bt;
        #1 chk("s_awready_idle", s_awready, 1);
        @(negedge clk);
        s_awvalid = 0;
        for (int k = 0; k < eq_addr.size(); k++) begin
            #1 t = 0;
            while (!m_awvalid && t < 20) begin @(negedge clk); #1 t++; end
            chk("m_awvalid", m_awvalid, 1);
            chk("m_awaddr", m_awaddr, eq_addr[k]);
            chk("m_awlen", m_awlen, eq_len[k]);
            chk("m_awburst", m_awburst, bt == 2'b00 ? 2'b00 : 2'b01);
            chk("s_awready_busy", s_awready, 0);
            m_awready = 1;
            @(negedge clk);
            m_awready = 0;
            for (int i = 0; i <= eq_len[k]; i++) begin
                d = $urandom;
                done = 0;
                while (!done) begin
                    s_wvalid = 1; s_wdata = d; s_wlast = 0;
                    m_wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                    #1;
                    chk("m_wvalid", m_wvalid, 1);
                    chk("m_wdata", m_wdata, d);
                    chk("m_wlast", m_wlast, i == eq_len[k]);
                    chk("s_wready", s_wready, m_wready);
                    done = m_wready;
                    @(negedge clk);
                end
            end
            s_wvalid = 0; m_wready = 0;
            #1 chk("m_bready", m_bready, 1);
            chk("s_bvalid_early", s_bvalid, 0);
            chk("m_wvalid_resp", m_wvalid, 0);
            for (int i = 0; i < brd; i++) begin @(negedge clk); #1; end
            m_bvalid = 1;
            @(negedge clk);
            m_bvalid = 0;
        end
        #1 chk("s_bvalid", s_bvalid, 1);
        chk("s_awready_bresp", s_awready, 0);
        @(negedge clk);
        #1 chk("s_bvalid_hold", s_bvalid, 1);
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
        #1 chk("s_bvalid_done", s_bvalid, 0);
        chk("s_awready_done", s_awready, 1);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_s_arready"}, s_arready, 1);
        chk({tag, "_s_awready"}, s_awready, 1);
        chk({tag, "_m_arvalid"}, m_arvalid, 0);
        chk({tag, "_m_awvalid"}, m_awvalid, 0);
        chk({tag, "_m_wvalid"}, m_wvalid, 0);
        chk({tag, "_s_wready"}, s_wready, 0);
        chk({tag, "_s_rvalid"}, s_rvalid, 0);
        chk({tag, "_m_rready"}, m_rready, 0);
        chk({tag, "_s_bvalid"}, s_bvalid, 0);
        chk({tag, "_m_bready"}, m_bready, 0);
        chk({tag, "_s_rlast"}, s_rlast, 0);
        chk({tag, "_m_wlast"}, m_wlast, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        #1 idle_checks("reset");
        rd(32'h0, 63, 2'b01, 0, 0);
        rd(32'hFF8, 3, 2'b01, 0, 0);
        wr(32'h100, 31, 2'b01, 0, 2);
        rd(32'h200, 19, 2'b00, 0, 0);
        rd(32'h1F0, 40, 2'b01, 1, 5);
        rd(32'h7FC, 0, 2'b10, 0, 1);
        wr(32'hFFC, 2, 2'b01, 1, 0);
        wr(32'h400, 17, 2'b00, 1, 1);
        // reset in the middle of a 32-beat write
        @(negedge clk);
        s_awvalid = 1; s_awaddr = 32'h300; s_awlen = 8'd31; s_awburst = 2'b01;
        @(negedge clk);
        s_awvalid = 0;
        m_awready = 1;
        @(negedge clk);
        m_awready = 0;
        for (int i = 0; i < 6; i++) begin
            s_wvalid = 1; m_wready = 1; s_wdata = 32'(i);
            @(negedge clk);
        end
        s_wvalid = 1; m_wready = 1; rst = 1;
        @(negedge clk);
        rst = 0; s_wvalid = 0; m_wready = 0;
        exp_rd_splits = 0; exp_wr_splits = 0;
        #1 idle_checks("midrst");
        wr(32'h300, 0, 2'b01, 0, 0);
        // simultaneous AR and AW acceptance
        @(negedge clk);
        s_arvalid = 1; s_araddr = 32'h40; s_arlen = 0; s_arburst = 2'b01;
        s_awvalid = 1; s_awaddr = 32'h80; s_awlen = 0; s_awburst = 2'b01;
        #1 chk("sim_arready", s_arready, 1);
        chk("sim_awready", s_awready, 1);
        @(negedge clk);
        s_arvalid = 0; s_awvalid = 0;
        #1 chk("sim_m_arvalid", m_arvalid, 1);
        chk("sim_m_awvalid", m_awvalid, 1);
        chk("sim_m_araddr", m_araddr, 32'h40);
        chk("sim_m_awaddr", m_awaddr, 32'h80);
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_rd_splits = 0; exp_wr_splits = 0;
        #1 idle_checks("simrst");
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a = $urandom;
            int len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
            logic [1:0] bt = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) rd(a, len, bt, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            else wr(a, len, bt, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
`ifdef GFX_AXIB_CHOP_STATS_EN
        chk("rd_splits", rd_splits, exp_rd_splits);
        chk("wr_splits", wr_splits, exp_wr_splits);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
